// File: rtl/vid_pkg.sv
// vid_pkg: shared op encodings, END flag positions and sequencer FSM states
package vid_pkg;
  typedef enum logic [1:0] {
    OP_CMD = 2'b00,
    OP_DAT = 2'b01,
    OP_DLY = 2'b10,
    OP_END = 2'b11
  } op_e;
  localparam int END_PP_BIT = 0;
  localparam int END_FM_BIT = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_SEND,
    ST_DELAY,
    ST_WAIT_FM
  } state_e;
endpackage

// File: rtl/vid_cmd_seq_tbl.sv
// vid_cmd_seq_tbl: 1R1W command table RAM, registered read returning old data on collision
module vid_cmd_seq_tbl #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] i_w_addr,
  input  logic [9:0]    i_w_data,
  input  logic          i_w_ena,
  input  logic [AW-1:0] i_r_addr,
  output logic [9:0]    o_r_data
);
  logic [9:0] r_mem [2**AW];
  logic [9:0] r_rd;
  // write port and registered read; read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (i_w_ena) r_mem[i_w_addr] <= i_w_data;
    r_rd <= r_mem[i_r_addr];
  end
  assign o_r_data = r_rd;
endmodule

// File: rtl/vid_cmd_seq.sv
// vid_cmd_seq: table-driven LCD command sequencer feeding the PHY byte stream
module vid_cmd_seq
  import vid_pkg::*;
#(
  parameter int TBL_AW    = 6,
  parameter int DLY_SHIFT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TBL_AW-1:0] tbl_w_addr,
  input  logic [9:0]        tbl_w_data,
  input  logic              tbl_w_ena,
  input  logic              run,
  input  logic [TBL_AW-1:0] run_addr,
  input  logic              abort,
  input  logic              fmark_stb,
  output logic [7:0]        phy_data,
  output logic              phy_rs,
  output logic              phy_valid,
  input  logic              phy_ready,
  output logic              pp_start,
  output logic              busy,
  output logic              err,
  output logic [TBL_AW-1:0] cur_addr
);
  localparam int CW = 8 + DLY_SHIFT;
  state_e            r_state, w_state;
  logic [TBL_AW-1:0] r_addr, w_addr;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [7:0]        r_data, w_data;
  logic              r_rs, w_rs;
  logic              r_valid, w_valid;
  logic              r_pp, w_pp;
  logic              r_flag, w_flag;
  logic              r_err, w_err;
  logic [9:0]        w_ent;
  op_e               w_op;
  logic [7:0]        w_arg;
  logic              w_last;
  vid_cmd_seq_tbl #(.AW(TBL_AW)) u_tbl (
    .clk      (clk),
    .i_w_addr (tbl_w_addr),
    .i_w_data (tbl_w_data),
    .i_w_ena  (tbl_w_ena),
    .i_r_addr (r_addr),
    .o_r_data (w_ent)
  );
  assign w_op   = op_e'(w_ent[9:8]);
  assign w_arg  = w_ent[7:0];
  assign w_last = &r_addr;
  // state register and all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_valid <= 1'b0;
      r_pp    <= 1'b0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_rs    <= w_rs;
      r_valid <= w_valid;
      r_pp    <= w_pp;
      r_flag  <= w_flag;
      r_err   <= w_err;
    end
  end
  // next-state and next-register logic; finishing the last table slot flags err instead of wrapping
  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_cnt   = r_cnt;
    w_data  = r_data;
    w_rs    = r_rs;
    w_valid = r_valid;
    w_pp    = 1'b0;
    w_flag  = r_flag;
    w_err   = r_err;
    if (abort) begin
      w_state = ST_IDLE;
      w_valid = 1'b0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (run) begin
          w_state = ST_FETCH;
          w_addr  = run_addr;
          w_err   = 1'b0;
        end
        ST_FETCH: w_state = ST_EXEC;
        ST_EXEC: case (w_op)
          OP_CMD, OP_DAT: begin
            w_data  = w_arg;
            w_rs    = w_op == OP_DAT;
            w_valid = 1'b1;
            w_state = ST_SEND;
          end
          OP_DLY: begin
            w_cnt   = {w_arg, {DLY_SHIFT{1'b0}}};
            w_state = ST_DELAY;
          end
          default: begin
            w_flag  = w_arg[END_PP_BIT];
            w_pp    = w_arg[END_FM_BIT] ? 1'b0 : w_arg[END_PP_BIT];
            w_state = w_arg[END_FM_BIT] ? ST_WAIT_FM : ST_IDLE;
          end
        endcase
        ST_SEND: if (phy_ready) begin
          w_valid = 1'b0;
          w_err   = r_err | w_last;
          w_addr  = w_last ? r_addr : r_addr + 1'b1;
          w_state = w_last ? ST_IDLE : ST_FETCH;
        end
        ST_DELAY: if (r_cnt == '0) begin
          w_err   = r_err | w_last;
          w_addr  = w_last ? r_addr : r_addr + 1'b1;
          w_state = w_last ? ST_IDLE : ST_FETCH;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
        ST_WAIT_FM: if (fmark_stb) begin
          w_pp    = r_flag;
          w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end
  assign phy_data  = r_data;
  assign phy_rs    = r_rs;
  assign phy_valid = r_valid;
  assign pp_start  = r_pp;
  assign busy      = r_state != ST_IDLE;
  assign err       = r_err;
  assign cur_addr  = r_addr;
endmodule
